// File: rtl/pipe_buf_stage.sv
// Reusable pipeline buffer stage: valid/ready handshake around an opaque payload.
// DEPTH = 2 gives a skid buffer with registered in_ready; DEPTH = 1 gives a single
// register with combinational pass-through ready. Includes a saturating stall counter.
module pipe_buf_stage #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count
);

  // Reject illegal configurations at elaboration time.
  if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
    $error("pipe_buf_stage: DEPTH must be 1 or 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_buf_stage: WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_buf_stage: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  localparam logic [CNT_W-1:0] StallMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] StallOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_data_q;
  logic [WIDTH-1:0] s_data_q;
  logic [CNT_W-1:0] stall_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_m_in;
  logic             load_m_skid;
  logic             load_s;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides the handshake and drops any same-cycle accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) state_d = StOne;
      end
      StOne: begin
        // In pass-through mode an accept while full always coincides with a drain.
        if (in_fire && !out_fire) begin
          state_d = (DEPTH == 2) ? StFull : StOne;
        end else if (!in_fire && out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) state_d = StOne;
      end
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  // Output decode from the state register (and out_ready for pass-through ready).
  always_comb begin
    out_valid = (state_q != StEmpty);
    occupancy = 2'd0;
    case (state_q)
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    if (DEPTH == 1) begin
      in_ready = (state_q == StEmpty) || out_ready;
    end else begin
      // Skid mode: ready depends only on flops, never on out_ready.
      in_ready = (state_q != StFull);
    end
  end

  // Data register load enables.
  always_comb begin
    load_m_in   = in_fire && ((state_q == StEmpty) || ((state_q == StOne) && out_fire));
    load_m_skid = (state_q == StFull) && out_fire;
    load_s      = in_fire && (state_q == StOne) && !out_fire;
  end

  // Payload registers; flush leaves contents untouched, reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_q <= '0;
      s_data_q <= '0;
    end else if (!flush) begin
      if (load_m_in) begin
        m_data_q <= in_data;
      end else if (load_m_skid) begin
        m_data_q <= s_data_q;
      end
      if (load_s) begin
        s_data_q <= in_data;
      end
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != StallMax)) begin
      stall_q <= stall_q + StallOne;
    end
  end

  assign out_data    = m_data_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Bench for pipe_buf_stage: a skid instance (DEPTH 2, 4-bit counter) and a
// pass-through instance (DEPTH 1) share stimulus; each is checked against a queue model.
module tb_pipe_buf_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [40:0] in_data;
  logic        out_ready;

  logic        in_ready2, out_valid2;
  logic [40:0] out_data2;
  logic [1:0]  occ2;
  logic [3:0]  stall2;

  logic        in_ready1, out_valid1;
  logic [40:0] out_data1;
  logic [1:0]  occ1;
  logic [15:0] stall1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: FIFO contents and stall counters.
  logic [40:0] q2[$];
  logic [40:0] q1[$];
  int          cnt2 = 0;
  int          cnt1 = 0;

  always #5 clk = ~clk;

  pipe_buf_stage #(.WIDTH(41), .DEPTH(2), .CNT_W(4)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready2),
    .in_data     (in_data),
    .out_valid   (out_valid2),
    .out_ready   (out_ready),
    .out_data    (out_data2),
    .occupancy   (occ2),
    .stall_count (stall2)
  );

  pipe_buf_stage #(.WIDTH(41), .DEPTH(1), .CNT_W(16)) u_pass (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready1),
    .in_data     (in_data),
    .out_valid   (out_valid1),
    .out_ready   (out_ready),
    .out_data    (out_data1),
    .occupancy   (occ1),
    .stall_count (stall1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, compare against the model, then advance model and clock.
  task automatic step(input logic r, input logic f, input logic iv, input logic [40:0] id,
                      input logic ordy);
    logic rdy2, rdy1, v2, v1;
    reset = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    v2   = (q2.size() > 0);
    v1   = (q1.size() > 0);
    rdy2 = (q2.size() < 2);
    rdy1 = (q1.size() == 0) || ordy;
    chk("skid_out_valid", {63'd0, out_valid2}, {63'd0, v2});
    chk("skid_occupancy", {62'd0, occ2}, 64'(q2.size()));
    chk("skid_in_ready", {63'd0, in_ready2}, {63'd0, rdy2});
    chk("skid_stall", {60'd0, stall2}, 64'(cnt2));
    chk("skid_data_known", {63'd0, $isunknown(out_data2)}, 64'd0);
    if (v2) chk("skid_out_data", {23'd0, out_data2}, {23'd0, q2[0]});
    chk("pass_out_valid", {63'd0, out_valid1}, {63'd0, v1});
    chk("pass_occupancy", {62'd0, occ1}, 64'(q1.size()));
    chk("pass_in_ready", {63'd0, in_ready1}, {63'd0, rdy1});
    chk("pass_stall", {48'd0, stall1}, 64'(cnt1));
    chk("pass_data_known", {63'd0, $isunknown(out_data1)}, 64'd0);
    if (v1) chk("pass_out_data", {23'd0, out_data1}, {23'd0, q1[0]});
    // Model advance: reset > flush > pop/push.
    if (r) begin
      q2.delete(); cnt2 = 0;
      q1.delete(); cnt1 = 0;
    end else begin
      if (v2 && !ordy && cnt2 < 15) cnt2++;
      if (v1 && !ordy && cnt1 < 65535) cnt1++;
      if (f) begin
        q2.delete();
        q1.delete();
      end else begin
        if (v2 && ordy) void'(q2.pop_front());
        if (iv && rdy2) q2.push_back(id);
        if (v1 && ordy) void'(q1.pop_front());
        if (iv && rdy1) q1.push_back(id);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          stall_before;
    logic [40:0] rd;
    logic        rr, rf, rv, ro;

    // First reset edge: outputs are unknown before it, so no checks yet.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 41'h155; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 41'h155, 1'b0);
    chk("rst_out_data", {23'd0, out_data2}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready2}, 64'd1);
    chk("rst_stall", {60'd0, stall2}, 64'd0);

    // Streaming through both instances.
    step(1'b0, 1'b0, 1'b1, 41'h11, 1'b1);
    step(1'b0, 1'b0, 1'b1, 41'h12, 1'b1);
    chk("stream_head", {23'd0, out_data2}, 64'h12);
    step(1'b0, 1'b0, 1'b1, 41'h13, 1'b1);
    step(1'b0, 1'b0, 1'b1, 41'h14, 1'b1);
    step(1'b0, 1'b0, 1'b1, 41'h15, 1'b1);
    chk("stream_occ", {62'd0, occ2}, 64'd1);
    step(1'b0, 1'b0, 1'b0, 41'h0, 1'b1);

    // Backpressure: A and B fill the skid buffer, C waits at the input.
    step(1'b0, 1'b0, 1'b1, 41'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 41'hB, 1'b0);
    chk("bp_occ_full", {62'd0, occ2}, 64'd2);
    chk("bp_in_ready_low", {63'd0, in_ready2}, 64'd0);
    chk("bp_pass_in_ready_low", {63'd0, in_ready1}, 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 41'hC, 1'b0);
    chk("bp_stall", {60'd0, stall2}, 64'd4);
    chk("bp_head_a", {23'd0, out_data2}, 64'hA);
    step(1'b0, 1'b0, 1'b1, 41'hC, 1'b1);
    chk("bp_head_b", {23'd0, out_data2}, 64'hB);
    step(1'b0, 1'b0, 1'b1, 41'hC, 1'b1);
    chk("bp_head_c", {23'd0, out_data2}, 64'hC);
    step(1'b0, 1'b0, 1'b0, 41'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 41'h0, 1'b1);

    // Flush from FULL with a payload offered; stall count must be preserved.
    step(1'b0, 1'b0, 1'b1, 41'h21, 1'b0);
    step(1'b0, 1'b0, 1'b1, 41'h22, 1'b0);
    stall_before = cnt2;
    step(1'b0, 1'b1, 1'b1, 41'h7, 1'b1);
    chk("flush_valid", {63'd0, out_valid2}, 64'd0);
    chk("flush_occ", {62'd0, occ2}, 64'd0);
    chk("flush_stall", {60'd0, stall2}, 64'(stall_before));
    chk("flush_pass_valid", {63'd0, out_valid1}, 64'd0);
    step(1'b0, 1'b0, 1'b0, 41'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 41'h0, 1'b1);

    // Pass-through: combinational ready follows out_ready while holding.
    step(1'b0, 1'b0, 1'b1, 41'h30, 1'b0);
    in_valid = 1'b1; in_data = 41'h3; out_ready = 1'b0;
    #1;
    chk("pt_ready_low", {63'd0, in_ready1}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("pt_ready_high", {63'd0, in_ready1}, 64'd1);
    step(1'b0, 1'b0, 1'b1, 41'h3, 1'b1);
    chk("pt_data", {23'd0, out_data1}, 64'h3);
    chk("pt_occ", {62'd0, occ1}, 64'd1);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 41'h40, 1'b0);
    chk("sat_15", {60'd0, stall2}, 64'd15);
    step(1'b0, 1'b0, 1'b0, 41'h0, 1'b0);
    chk("sat_hold", {60'd0, stall2}, 64'd15);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rd = 41'({$urandom(), $urandom()});
      rr = ($urandom_range(63) == 0);
      rf = ($urandom_range(15) == 0);
      rv = 1'($urandom_range(1));
      ro = ($urandom_range(3) != 0);
      step(rr, rf, rv, rd, ro);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
